hk_spi_initiator: RTL and testbench

HK_SPI_INITIATOR -- requirements
Module: hk_spi_initiator

---
 rtl/hk_spi_initiator.sv | 260 ++++++++++++++++++++++++++
 tb/tb_hk_spi_initiator.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hk_spi_initiator.sv
// SPI mode-0 initiator for the housekeeping streaming protocol (command, address, data bytes).
// Optional macro HK_SPI_INITIATOR_CSB_GAP_EN adds a csb-high GAP state of 4*CLK_DIV cycles after each frame.
module hk_spi_initiator #(
    parameter int CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       start,
    input  logic       cmd_write,
    input  logic [7:0] addr,
    input  logic [3:0] len,
    input  logic [7:0] wdata,
    input  logic       wdata_valid,
    output logic       wdata_ready,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       busy,
    output logic       done,
    output logic       csb,
    output logic       sck,
    output logic       sdo,
    input  logic       sdi
);

`ifdef HK_SPI_INITIATOR_CSB_GAP_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        STALL = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;
    localparam logic [9:0] GAP_LAST = 10'(4 * CLK_DIV - 1);
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        STALL = 3'd3,
        HOLD  = 3'd4
    } state_t;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    function automatic logic [7:0] cmd_byte(input logic wr);
        return wr ? 8'h80 : 8'h40;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] div_cnt_r;
    logic [2:0] bit_cnt_r;
    logic [4:0] byte_cnt_r;
    logic [7:0] shift_r;
    logic [7:0] rx_r;
    logic       rx_pend_r;
    logic       cmd_r;
    logic [7:0] addr_r;
    logic [3:0] len_r;
    logic       csb_r;
    logic       sck_r;
    logic       sdo_r;
    logic       busy_r;
    logic       done_r;
    logic       wdata_ready_r;
    logic       rdata_valid_r;
    logic [7:0] rdata_r;
`ifdef HK_SPI_INITIATOR_CSB_GAP_EN
    logic [9:0] gap_cnt_r;
`endif

    logic tick_s;
    logic accept_s;
    logic rise_s;
    logic fall_s;
    logic boundary_s;
    logic need_wdata_s;
    logic load_w_s;
    logic last_rise_s;
    logic hold_end_s;

    // Timing strobes derived from the half-period counter and bit/byte position.
    always_comb begin
        tick_s       = (div_cnt_r == DIV_LAST);
        accept_s     = (state_r == IDLE) && start && (len != 4'd0);
        rise_s       = tick_s && !sck_r && ((state_r == SETUP) || (state_r == SHIFT));
        fall_s       = tick_s && sck_r && (state_r == SHIFT);
        boundary_s   = fall_s && (bit_cnt_r == 3'd0);
        need_wdata_s = boundary_s && cmd_r && (byte_cnt_r >= 5'd2);
        load_w_s     = (need_wdata_s && wdata_valid) || ((state_r == STALL) && wdata_valid);
        last_rise_s  = rise_s && (bit_cnt_r == 3'd7) && (byte_cnt_r == ({1'b0, len_r} + 5'd1));
        hold_end_s   = (state_r == HOLD) && tick_s && !sck_r;
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = SETUP;
                else          state_nxt_s = IDLE;
            end
            SETUP: begin
                if (tick_s) state_nxt_s = SHIFT;
                else        state_nxt_s = SETUP;
            end
            SHIFT: begin
                if (last_rise_s)                        state_nxt_s = HOLD;
                else if (need_wdata_s && !wdata_valid)  state_nxt_s = STALL;
                else                                    state_nxt_s = SHIFT;
            end
            STALL: begin
                if (wdata_valid) state_nxt_s = SHIFT;
                else             state_nxt_s = STALL;
            end
            HOLD: begin
`ifdef HK_SPI_INITIATOR_CSB_GAP_EN
                if (hold_end_s) state_nxt_s = GAP;
                else            state_nxt_s = HOLD;
`else
                if (hold_end_s) state_nxt_s = IDLE;
                else            state_nxt_s = HOLD;
`endif
            end
`ifdef HK_SPI_INITIATOR_CSB_GAP_EN
            GAP: begin
                if (gap_cnt_r == GAP_LAST) state_nxt_s = IDLE;
                else                       state_nxt_s = GAP;
            end
`endif
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state_r <= IDLE;
        else         state_r <= state_nxt_s;
    end

    // Frame datapath: SPI pins, shift registers, counters and handshake pulses.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            div_cnt_r     <= 8'd0;
            bit_cnt_r     <= 3'd0;
            byte_cnt_r    <= 5'd0;
            shift_r       <= 8'h00;
            rx_r          <= 8'h00;
            rx_pend_r     <= 1'b0;
            cmd_r         <= 1'b0;
            addr_r        <= 8'h00;
            len_r         <= 4'd0;
            csb_r         <= 1'b1;
            sck_r         <= 1'b0;
            sdo_r         <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            wdata_ready_r <= 1'b0;
            rdata_valid_r <= 1'b0;
            rdata_r       <= 8'h00;
`ifdef HK_SPI_INITIATOR_CSB_GAP_EN
            gap_cnt_r     <= 10'd0;
`endif
        end else begin
            done_r        <= 1'b0;
            wdata_ready_r <= 1'b0;
            rdata_valid_r <= 1'b0;

            // The counter restarts on every toggle and every state change, so a STALL never shortens a half-period.
            if (tick_s || (state_nxt_s != state_r) || (state_r == IDLE) || (state_r == STALL))
                div_cnt_r <= 8'd0;
            else
                div_cnt_r <= div_cnt_r + 8'd1;

            if (rx_pend_r) begin
                rdata_r       <= rx_r;
                rdata_valid_r <= 1'b1;
                rx_pend_r     <= 1'b0;
            end

            if (accept_s) begin
                csb_r      <= 1'b0;
                busy_r     <= 1'b1;
                cmd_r      <= cmd_write;
                addr_r     <= addr;
                len_r      <= len;
                shift_r    <= cmd_byte(cmd_write);
                sdo_r      <= cmd_byte(cmd_write) >> 7;
                bit_cnt_r  <= 3'd0;
                byte_cnt_r <= 5'd0;
            end

            if (rise_s) begin
                sck_r     <= 1'b1;
                rx_r      <= {rx_r[6:0], sdi};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    byte_cnt_r <= byte_cnt_r + 5'd1;
                    if (!cmd_r && (byte_cnt_r >= 5'd2)) rx_pend_r <= 1'b1;
                end
            end

            if (fall_s) begin
                sck_r <= 1'b0;
                if (bit_cnt_r != 3'd0) begin
                    shift_r <= {shift_r[6:0], 1'b0};
                    sdo_r   <= shift_r[6];
                end else if (byte_cnt_r == 5'd1) begin
                    shift_r <= addr_r;
                    sdo_r   <= addr_r[7];
                end else if (!cmd_r) begin
                    shift_r <= 8'h00;
                    sdo_r   <= 1'b0;
                end
            end

            if (load_w_s) begin
                shift_r       <= wdata;
                sdo_r         <= wdata[7];
                wdata_ready_r <= 1'b1;
            end

            if ((state_r == HOLD) && tick_s) begin
                if (sck_r) begin
                    sck_r <= 1'b0;
                end else begin
                    csb_r  <= 1'b1;
                    done_r <= 1'b1;
                    sdo_r  <= 1'b0;
`ifdef HK_SPI_INITIATOR_CSB_GAP_EN
                    busy_r <= 1'b1;
`else
                    busy_r <= 1'b0;
`endif
                end
            end

`ifdef HK_SPI_INITIATOR_CSB_GAP_EN
            if (state_r == GAP) begin
                gap_cnt_r <= gap_cnt_r + 10'd1;
                if (gap_cnt_r == GAP_LAST) busy_r <= 1'b0;
            end else begin
                gap_cnt_r <= 10'd0;
            end
`endif
        end
    end

    assign csb         = csb_r;
    assign sck         = sck_r;
    assign sdo         = sdo_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign wdata_ready = wdata_ready_r;
    assign rdata_valid = rdata_valid_r;
    assign rdata       = rdata_r;

endmodule

// File: tb/tb_hk_spi_initiator.sv
// Directed self-checking bench for hk_spi_initiator: one instance at CLK_DIV=4 (a), one at CLK_DIV=2 (b),
// each with a housekeeping SDO model and pin monitors sampled on the falling system-clock edge.
module tb_hk_spi_initiator;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [3:0] len = 4'd0;
    logic [7:0] wdata = 8'h00;
    logic       wdata_valid = 1'b0;

    logic       wdata_ready_a, rdata_valid_a, busy_a, done_a, csb_a, sck_a, sdo_a;
    logic [7:0] rdata_a;
    logic       sdi_a = 1'b0;
    logic       wdata_ready_b, rdata_valid_b, busy_b, done_b, csb_b, sck_b, sdo_b;
    logic [7:0] rdata_b;
    logic       sdi_b = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    hk_spi_initiator #(.CLK_DIV(4)) dut_a (
        .clock(clock), .resetb(resetb), .start(start_a), .cmd_write(cmd_write),
        .addr(addr), .len(len), .wdata(wdata), .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready_a), .rdata(rdata_a), .rdata_valid(rdata_valid_a),
        .busy(busy_a), .done(done_a), .csb(csb_a), .sck(sck_a), .sdo(sdo_a), .sdi(sdi_a)
    );

    hk_spi_initiator #(.CLK_DIV(2)) dut_b (
        .clock(clock), .resetb(resetb), .start(start_b), .cmd_write(cmd_write),
        .addr(addr), .len(len), .wdata(wdata), .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready_b), .rdata(rdata_b), .rdata_valid(rdata_valid_b),
        .busy(busy_b), .done(done_b), .csb(csb_b), .sck(sck_b), .sdo(sdo_b), .sdi(sdi_b)
    );

    // Monitor and SDO model state for instance a.
    int          rise_a = 0, done_cnt_a = 0, wr_cnt_a = 0, rv_cnt_a = 0, high_run_a = 0, last_high_a = 0;
    logic [63:0] bits_a = 64'h0;
    logic [23:0] rd_hist_a = 24'h0;
    logic [127:0] tx_a = 128'h0;
    logic [6:0]  ptr_a = 7'd0;
    logic        sck_pa = 1'b0, csb_pa = 1'b1;

    always @(negedge clock) begin
        if (sck_a && !sck_pa) begin
            rise_a = rise_a + 1;
            bits_a = {bits_a[62:0], sdo_a};
        end
        if (!csb_a && csb_pa) begin
            ptr_a = 7'd0;
            sdi_a = tx_a[127];
        end else if (!csb_a && !sck_a && sck_pa) begin
            if (ptr_a != 7'd127) ptr_a = ptr_a + 7'd1;
            sdi_a = tx_a[7'd127 - ptr_a];
        end
        if (done_a) done_cnt_a = done_cnt_a + 1;
        if (wdata_ready_a) wr_cnt_a = wr_cnt_a + 1;
        if (rdata_valid_a) begin
            rv_cnt_a = rv_cnt_a + 1;
            rd_hist_a = {rd_hist_a[15:0], rdata_a};
        end
        if (csb_a) begin
            high_run_a = high_run_a + 1;
        end else begin
            if (csb_pa) last_high_a = high_run_a;
            high_run_a = 0;
        end
        sck_pa = sck_a;
        csb_pa = csb_a;
    end

    // Monitor and SDO model state for instance b.
    int          rise_b = 0, done_cnt_b = 0, wr_cnt_b = 0, rv_cnt_b = 0;
    logic [63:0] bits_b = 64'h0;
    logic [23:0] rd_hist_b = 24'h0;
    logic [127:0] tx_b = 128'h0;
    logic [6:0]  ptr_b = 7'd0;
    logic        sck_pb = 1'b0, csb_pb = 1'b1;

    always @(negedge clock) begin
        if (sck_b && !sck_pb) begin
            rise_b = rise_b + 1;
            bits_b = {bits_b[62:0], sdo_b};
        end
        if (!csb_b && csb_pb) begin
            ptr_b = 7'd0;
            sdi_b = tx_b[127];
        end else if (!csb_b && !sck_b && sck_pb) begin
            if (ptr_b != 7'd127) ptr_b = ptr_b + 7'd1;
            sdi_b = tx_b[7'd127 - ptr_b];
        end
        if (done_b) done_cnt_b = done_cnt_b + 1;
        if (wdata_ready_b) wr_cnt_b = wr_cnt_b + 1;
        if (rdata_valid_b) begin
            rv_cnt_b = rv_cnt_b + 1;
            rd_hist_b = {rd_hist_b[15:0], rdata_b};
        end
        sck_pb = sck_b;
        csb_pb = csb_b;
    end

    task automatic pulse_start(input bit which);
        int n;
        n = 0;
        while ((which ? busy_b : busy_a) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int budget);
        int n;
        n = 0;
        while (!(which ? done_b : done_a) && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!(which ? done_b : done_a)) begin
            failures++;
            $display("FAIL done_timeout: dut %0d no done after %0d cycles", which, budget);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        checks++; if (csb_a !== 1'b1) begin failures++; $display("FAIL rst_csb: got %b want 1", csb_a); end
        checks++; if (sck_a !== 1'b0) begin failures++; $display("FAIL rst_sck: got %b want 0", sck_a); end
        checks++; if (sdo_a !== 1'b0) begin failures++; $display("FAIL rst_sdo: got %b want 0", sdo_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        checks++; if (rdata_a !== 8'h00) begin failures++; $display("FAIL rst_rdata: got %h want 00", rdata_a); end
        checks++;
        if ({done_a, wdata_ready_a, rdata_valid_a} !== 3'b000) begin
            failures++; $display("FAIL rst_pulses: got %b want 000", {done_a, wdata_ready_a, rdata_valid_a});
        end
        checks++; if (csb_b !== 1'b1) begin failures++; $display("FAIL rst_csb_b: got %b want 1", csb_b); end
        resetb = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_write;
        int r0, d0, w0, v0;
        cmd_write = 1'b1; addr = 8'h08; len = 4'd1; wdata = 8'hA5; wdata_valid = 1'b1;
        r0 = rise_a; d0 = done_cnt_a; w0 = wr_cnt_a; v0 = rv_cnt_a;
        pulse_start(1'b0);
        checks++; if (csb_a !== 1'b0) begin failures++; $display("FAIL wr_csb_low: got %b want 0", csb_a); end
        checks++; if (sdo_a !== 1'b1) begin failures++; $display("FAIL wr_cmd_bit7: got %b want 1", sdo_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL wr_busy: got %b want 1", busy_a); end
        wait_done(1'b0, 600);
        repeat (2) @(negedge clock);
        checks++; if (bits_a[23:0] !== 24'h8008A5) begin failures++; $display("FAIL wr_bits: got %h want 8008a5", bits_a[23:0]); end
        checks++; if (rise_a - r0 != 24) begin failures++; $display("FAIL wr_rises: got %0d want 24", rise_a - r0); end
        checks++; if (wr_cnt_a - w0 != 1) begin failures++; $display("FAIL wr_ready: got %0d want 1", wr_cnt_a - w0); end
        checks++; if (done_cnt_a - d0 != 1) begin failures++; $display("FAIL wr_done: got %0d want 1", done_cnt_a - d0); end
        checks++; if (rv_cnt_a - v0 != 0) begin failures++; $display("FAIL wr_no_rvalid: got %0d want 0", rv_cnt_a - v0); end
        wdata_valid = 1'b0;
    endtask

    task automatic test_read;
        int r0, d0, w0, v0;
        cmd_write = 1'b0; addr = 8'h01; len = 4'd3; wdata_valid = 1'b0;
        tx_b = {8'hFF, 8'hC3, 8'h12, 8'h34, 8'h56, 88'h0};
        r0 = rise_b; d0 = done_cnt_b; w0 = wr_cnt_b; v0 = rv_cnt_b;
        pulse_start(1'b1);
        wait_done(1'b1, 600);
        repeat (2) @(negedge clock);
        checks++; if (rv_cnt_b - v0 != 3) begin failures++; $display("FAIL rd_count: got %0d want 3", rv_cnt_b - v0); end
        checks++; if (rd_hist_b !== 24'h123456) begin failures++; $display("FAIL rd_data: got %h want 123456", rd_hist_b); end
        checks++; if (rise_b - r0 != 40) begin failures++; $display("FAIL rd_rises: got %0d want 40", rise_b - r0); end
        checks++; if (bits_b[39:0] !== 40'h4001000000) begin failures++; $display("FAIL rd_sdo: got %h want 4001000000", bits_b[39:0]); end
        checks++; if (wr_cnt_b - w0 != 0) begin failures++; $display("FAIL rd_no_wready: got %0d want 0", wr_cnt_b - w0); end
        checks++; if (done_cnt_b - d0 != 1) begin failures++; $display("FAIL rd_done: got %0d want 1", done_cnt_b - d0); end
    endtask

    task automatic test_stall;
        int r0, d0, w0, n;
        bit held;
        cmd_write = 1'b1; addr = 8'h20; len = 4'd2; wdata = 8'hC6; wdata_valid = 1'b1;
        r0 = rise_a; d0 = done_cnt_a; w0 = wr_cnt_a;
        pulse_start(1'b0);
        n = 0;
        while (!wdata_ready_a && n < 400) begin @(negedge clock); n++; end
        wdata_valid = 1'b0;
        n = 0;
        while (!((rise_a - r0 >= 24) && !sck_a) && n < 400) begin @(negedge clock); n++; end
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (sck_a !== 1'b0 || csb_a !== 1'b0) held = 1'b0;
        end
        checks++; if (!held) begin failures++; $display("FAIL stall_hold: sck/csb moved during stall, want sck=0 csb=0"); end
        checks++; if (rise_a - r0 != 24) begin failures++; $display("FAIL stall_rises: got %0d want 24", rise_a - r0); end
        wdata = 8'h3C; wdata_valid = 1'b1;
        n = 0;
        while (!wdata_ready_a && n < 50) begin @(negedge clock); n++; end
        wdata_valid = 1'b0;
        wait_done(1'b0, 600);
        repeat (2) @(negedge clock);
        checks++; if (bits_a[31:0] !== 32'h8020C63C) begin failures++; $display("FAIL stall_bits: got %h want 8020c63c", bits_a[31:0]); end
        checks++; if (rise_a - r0 != 32) begin failures++; $display("FAIL stall_total_rises: got %0d want 32", rise_a - r0); end
        checks++; if (wr_cnt_a - w0 != 2) begin failures++; $display("FAIL stall_ready: got %0d want 2", wr_cnt_a - w0); end
        checks++; if (done_cnt_a - d0 != 1) begin failures++; $display("FAIL stall_done: got %0d want 1", done_cnt_a - d0); end
    endtask

    task automatic test_illegal_start;
        int r0, d0, w0, v0, n;
        bit quiet;
        cmd_write = 1'b1; addr = 8'h55; len = 4'd0; wdata = 8'h77; wdata_valid = 1'b1;
        d0 = done_cnt_a; w0 = wr_cnt_a; v0 = rv_cnt_a;
        pulse_start(1'b0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (csb_a !== 1'b1 || busy_a !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL len0_quiet: csb/busy activity on len=0 start"); end
        checks++;
        if ((done_cnt_a - d0) + (wr_cnt_a - w0) + (rv_cnt_a - v0) != 0) begin
            failures++; $display("FAIL len0_pulses: got %0d pulses want 0", (done_cnt_a - d0) + (wr_cnt_a - w0) + (rv_cnt_a - v0));
        end
        addr = 8'h3E; len = 4'd1;
        r0 = rise_a; d0 = done_cnt_a; w0 = wr_cnt_a; v0 = rv_cnt_a;
        pulse_start(1'b0);
        n = 0;
        while ((rise_a - r0 < 4) && n < 200) begin @(negedge clock); n++; end
        addr = 8'hFF; len = 4'd7; cmd_write = 1'b0; wdata = 8'h11;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        addr = 8'h00;
        wdata = 8'h77;
        wait_done(1'b0, 600);
        repeat (2) @(negedge clock);
        checks++; if (bits_a[23:0] !== 24'h803E77) begin failures++; $display("FAIL busy_start_bits: got %h want 803e77", bits_a[23:0]); end
        checks++; if (rise_a - r0 != 24) begin failures++; $display("FAIL busy_start_rises: got %0d want 24", rise_a - r0); end
        checks++; if (done_cnt_a - d0 != 1) begin failures++; $display("FAIL busy_start_done: got %0d want 1", done_cnt_a - d0); end
        checks++; if (wr_cnt_a - w0 != 1) begin failures++; $display("FAIL busy_start_ready: got %0d want 1", wr_cnt_a - w0); end
        checks++; if (rv_cnt_a - v0 != 0) begin failures++; $display("FAIL busy_start_rvalid: got %0d want 0", rv_cnt_a - v0); end
        wdata_valid = 1'b0;
    endtask

    task automatic test_reset_midframe;
        int r0, d0, v0, n;
        cmd_write = 1'b0; addr = 8'h10; len = 4'd2; wdata_valid = 1'b0;
        tx_a = {8'hFF, 8'hC3, 8'hAB, 8'hCD, 96'h0};
        r0 = rise_a; d0 = done_cnt_a;
        pulse_start(1'b0);
        n = 0;
        while ((rise_a - r0 < 10) && n < 400) begin @(negedge clock); n++; end
        resetb = 1'b0;
        #1;
        checks++; if (csb_a !== 1'b1) begin failures++; $display("FAIL rstmid_csb: got %b want 1", csb_a); end
        checks++; if (sck_a !== 1'b0) begin failures++; $display("FAIL rstmid_sck: got %b want 0", sck_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy_a); end
        @(negedge clock);
        resetb = 1'b1;
        repeat (60) @(negedge clock);
        checks++; if (done_cnt_a - d0 != 0) begin failures++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt_a - d0); end
        r0 = rise_a; d0 = done_cnt_a; v0 = rv_cnt_a;
        pulse_start(1'b0);
        wait_done(1'b0, 600);
        repeat (2) @(negedge clock);
        checks++; if (rv_cnt_a - v0 != 2) begin failures++; $display("FAIL rstmid_rd_count: got %0d want 2", rv_cnt_a - v0); end
        checks++; if (rd_hist_a[15:0] !== 16'hABCD) begin failures++; $display("FAIL rstmid_rd_data: got %h want abcd", rd_hist_a[15:0]); end
        checks++; if (rise_a - r0 != 32) begin failures++; $display("FAIL rstmid_rises: got %0d want 32", rise_a - r0); end
    endtask

    task automatic test_back_to_back;
        int r0, d0;
        cmd_write = 1'b1; addr = 8'h22; len = 4'd1; wdata = 8'h5A; wdata_valid = 1'b1;
        r0 = rise_a; d0 = done_cnt_a;
        pulse_start(1'b0);
        wait_done(1'b0, 600);
        pulse_start(1'b0);
        wait_done(1'b0, 600);
        repeat (2) @(negedge clock);
        wdata_valid = 1'b0;
`ifdef HK_SPI_INITIATOR_CSB_GAP_EN
        checks++; if (last_high_a < 16) begin failures++; $display("FAIL b2b_gap: csb high %0d cycles want >=16", last_high_a); end
`else
        checks++; if (last_high_a != 1) begin failures++; $display("FAIL b2b_gap: csb high %0d cycles want 1", last_high_a); end
`endif
        checks++; if (done_cnt_a - d0 != 2) begin failures++; $display("FAIL b2b_done: got %0d want 2", done_cnt_a - d0); end
        checks++; if (rise_a - r0 != 48) begin failures++; $display("FAIL b2b_rises: got %0d want 48", rise_a - r0); end
        checks++; if (bits_a[47:0] !== 48'h80225A80225A) begin failures++; $display("FAIL b2b_bits: got %h want 80225a80225a", bits_a[47:0]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_illegal_start();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
